// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - LCD bus encodings, instruction opcodes and responder states shared with the LCD driver
package lcd_pkg;

  localparam logic LCD_RS_INSTR = 1'b0;
  localparam logic LCD_RS_DATA  = 1'b1;
  localparam logic LCD_RW_WRITE = 1'b0;
  localparam logic LCD_RW_READ  = 1'b1;

  localparam logic [7:0] Dsp_Clear  = 8'h01;
  localparam logic [7:0] Ret_Home   = 8'h02;
  localparam logic [7:0] Entry_Mode = 8'h04;
  localparam logic [7:0] Disp_Ctrl  = 8'h08;
  localparam logic [7:0] Cur_Shift  = 8'h10;
  localparam logic [7:0] Func_Set   = 8'h20;
  localparam logic [7:0] Cgram_Set  = 8'h40;
  localparam logic [7:0] Ddram_Set  = 8'h80;

  localparam logic [2:0] ST_OFF      = 3'd0;
  localparam logic [2:0] ST_POWERUP  = 3'd1;
  localparam logic [2:0] ST_IDLE     = 3'd2;
  localparam logic [2:0] ST_BUSY     = 3'd3;
  localparam logic [2:0] ST_CLEARING = 3'd4;

  // Address counter is 7-bit and wraps in both directions.
  function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic inc);
    return inc ? ac + 7'd1 : ac - 7'd1;
  endfunction

endpackage

// File: rtl/lcd_ddram.sv
// rtl/lcd_ddram.sv - 128x8 display RAM: one write port, async bus read port, registered debug read port
module lcd_ddram (
  input  logic       i_clk,
  input  logic       i_we,
  input  logic [6:0] i_waddr,
  input  logic [7:0] i_wdata,
  input  logic [6:0] i_raddr,
  output logic [7:0] o_rdata,
  input  logic [6:0] i_dbg_addr,
  output logic [7:0] o_dbg_data
);

  logic [7:0] r_mem [0:127];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    o_dbg_data <= r_mem[i_dbg_addr];
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/lcd_bus_responder.sv
// rtl/lcd_bus_responder.sv - HD44780-style responder: decodes the 8-bit LCD bus, keeps DDRAM and AC, times busy
module lcd_bus_responder
  import lcd_pkg::*;
#(
  parameter int CLEAR_CYCLES   = 128,
  parameter int HOME_CYCLES    = 64,
  parameter int INSTR_CYCLES   = 16,
  parameter int POWERUP_CYCLES = 256
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_lcd_power,
  input  logic       i_lcd_en,
  input  logic       i_lcd_rs,
  input  logic       i_lcd_rw,
  input  logic [7:0] i_lcd_data_in,
  output logic [7:0] o_lcd_data_out,
  output logic       o_lcd_data_oe,
  output logic       o_busy,
  output logic [6:0] o_ac,
  output logic       o_disp_on,
  output logic       o_cursor_on,
  output logic       o_blink_on,
  output logic       o_entry_inc,
  output logic       o_entry_shift,
  output logic [7:0] o_violation_count,
  input  logic [6:0] i_dbg_addr,
  output logic [7:0] o_dbg_data
);

  localparam logic [15:0] CLEAR_LOAD   = 16'(CLEAR_CYCLES);
  localparam logic [15:0] HOME_LOAD    = 16'(HOME_CYCLES);
  localparam logic [15:0] INSTR_LOAD   = 16'(INSTR_CYCLES);
  localparam logic [15:0] POWERUP_LOAD = 16'(POWERUP_CYCLES);

  logic [2:0]  r_state;
  logic [15:0] r_cnt;
  logic [6:0]  r_clr_ptr;
  logic        r_en_q;
  logic [6:0]  r_ac;
  logic [7:0]  r_lcd_data_out;
  logic        r_lcd_data_oe;
  logic        r_disp_on, r_cursor_on, r_blink_on, r_entry_inc, r_entry_shift;
  logic [7:0]  r_violation_count;

  logic        w_busy, w_fall, w_wr, w_clearing, w_data_wr, w_we;
  logic [6:0]  w_waddr;
  logic [7:0]  w_wdata, w_bus_rd;

  assign w_busy     = (r_state != ST_IDLE);
  assign w_fall     = r_en_q & ~i_lcd_en;
  assign w_wr       = w_fall & (i_lcd_rw == LCD_RW_WRITE);
  assign w_clearing = (r_state == ST_CLEARING) & i_lcd_power & ~i_reset;
  assign w_data_wr  = w_wr & (i_lcd_rs == LCD_RS_DATA) & (r_state == ST_IDLE) & i_lcd_power & ~i_reset;
  assign w_we       = w_clearing | w_data_wr;
  assign w_waddr    = w_clearing ? r_clr_ptr : r_ac;
  assign w_wdata    = w_clearing ? 8'h20 : i_lcd_data_in;

  lcd_ddram u_ddram (
    .i_clk      (i_clk),
    .i_we       (w_we),
    .i_waddr    (w_waddr),
    .i_wdata    (w_wdata),
    .i_raddr    (r_ac),
    .o_rdata    (w_bus_rd),
    .i_dbg_addr (i_dbg_addr),
    .o_dbg_data (o_dbg_data)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state           <= ST_OFF;
      r_cnt             <= '0;
      r_clr_ptr         <= '0;
      r_en_q            <= 1'b0;
      r_ac              <= '0;
      r_lcd_data_out    <= '0;
      r_lcd_data_oe     <= 1'b0;
      r_disp_on         <= 1'b0;
      r_cursor_on       <= 1'b0;
      r_blink_on        <= 1'b0;
      r_entry_inc       <= 1'b1;
      r_entry_shift     <= 1'b0;
      r_violation_count <= '0;
    end else begin
      r_en_q <= i_lcd_en;
      if (!i_lcd_power) begin
        r_state       <= ST_OFF;
        r_cnt         <= '0;
        r_clr_ptr     <= '0;
        r_lcd_data_oe <= 1'b0;
      end else if (r_state == ST_OFF) begin
        r_state <= ST_POWERUP;
        r_cnt   <= POWERUP_LOAD;
      end else begin
        if (i_lcd_en && (i_lcd_rw == LCD_RW_READ)) begin
          r_lcd_data_oe  <= 1'b1;
          r_lcd_data_out <= (i_lcd_rs == LCD_RS_DATA) ? w_bus_rd : {w_busy, r_ac};
        end else if (!i_lcd_en) begin
          r_lcd_data_oe <= 1'b0;
        end

        // Any write landing outside IDLE is dropped and counted.
        if (w_wr && w_busy && (r_violation_count != 8'hFF))
          r_violation_count <= r_violation_count + 8'd1;

        if (r_state == ST_POWERUP || r_state == ST_BUSY) begin
          if (r_cnt <= 16'd1) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end else if (r_state == ST_CLEARING) begin
          r_clr_ptr <= r_clr_ptr + 7'd1;
          r_cnt     <= r_cnt - 16'd1;
          if (r_clr_ptr == 7'd127)
            r_state <= (r_cnt <= 16'd1) ? ST_IDLE : ST_BUSY;
        end else if (w_wr) begin
          r_state <= ST_BUSY;
          r_cnt   <= INSTR_LOAD;
          if (i_lcd_rs == LCD_RS_DATA) begin
            r_ac <= ac_step(r_ac, r_entry_inc);
          end else if (|(i_lcd_data_in & Ddram_Set)) begin
            r_ac <= i_lcd_data_in[6:0];
          end else if (|(i_lcd_data_in & (Cgram_Set | Func_Set))) begin
          end else if (|(i_lcd_data_in & Cur_Shift)) begin
            if (!i_lcd_data_in[3]) r_ac <= ac_step(r_ac, i_lcd_data_in[2]);
          end else if (|(i_lcd_data_in & Disp_Ctrl)) begin
            r_disp_on   <= i_lcd_data_in[2];
            r_cursor_on <= i_lcd_data_in[1];
            r_blink_on  <= i_lcd_data_in[0];
          end else if (|(i_lcd_data_in & Entry_Mode)) begin
            r_entry_inc   <= i_lcd_data_in[1];
            r_entry_shift <= i_lcd_data_in[0];
          end else if (|(i_lcd_data_in & Ret_Home)) begin
            r_ac  <= '0;
            r_cnt <= HOME_LOAD;
          end else if (|(i_lcd_data_in & Dsp_Clear)) begin
            r_ac        <= '0;
            r_entry_inc <= 1'b1;
            r_state     <= ST_CLEARING;
            r_cnt       <= CLEAR_LOAD;
            r_clr_ptr   <= '0;
          end
        end else if (w_fall && (i_lcd_rs == LCD_RS_DATA)) begin
          r_ac <= ac_step(r_ac, r_entry_inc);
        end
      end
    end
  end

  assign o_lcd_data_out    = r_lcd_data_out;
  assign o_lcd_data_oe     = r_lcd_data_oe;
  assign o_busy            = w_busy;
  assign o_ac              = r_ac;
  assign o_disp_on         = r_disp_on;
  assign o_cursor_on       = r_cursor_on;
  assign o_blink_on        = r_blink_on;
  assign o_entry_inc       = r_entry_inc;
  assign o_entry_shift     = r_entry_shift;
  assign o_violation_count = r_violation_count;

endmodule
